scratchpad_arbiter: RTL

SCRATCHPAD_ARBITER -- requirements
Module: scratchpad_arbiter

---
 rtl/scratchpad_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: arbitrates CPU, host (optional, macro SCRATCHPAD_HOST_PORT_EN) and periodic refresh access to an 8x8 scratchpad array
// Ports: sysclk/poc (clock, sync active-high reset); cpu_* and host_* nibble access ports (req/we/addr/wdata in, ack/rdata out);
// arr_row/arr_rd/arr_wr/arr_wdata/arr_rdata row-wide array interface; busy when an access is in flight.
module scratchpad_arbiter #(
  parameter int REFRESH_INTERVAL = 64,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [3:0] cpu_rdata,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [3:0] host_wdata,
  output logic       host_ack,
  output logic [3:0] host_rdata,
  output logic [2:0] arr_row,
  output logic       arr_rd,
  output logic       arr_wr,
  output logic [7:0] arr_wdata,
  input  logic [7:0] arr_rdata,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WB} state_t;
  typedef enum logic [1:0] {SRC_CPU, SRC_HOST, SRC_RF} src_t;
  localparam logic [7:0] RI_LAST = 8'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] HMW = 4'(HOST_MAX_WAIT);
  state_t state;
  src_t src;
  logic [7:0] icnt;
  logic rf_pend;
  logic [2:0] rfsh;
  logic [3:0] host_wait;
  logic [3:0] addr_q, wdata_q, cpu_rd_q, host_rd_q;
  logic we_q;
  logic [7:0] buf_q;
  logic host_go, host_force, idle, grant_rf, grant_host, grant_cpu;
  logic [3:0] nib;
  logic [7:0] merged;
`ifdef SCRATCHPAD_HOST_PORT_EN
  assign host_go = host_req;
  assign host_ack = (src == SRC_HOST) && (state == CAP || state == WB);
  assign host_rdata = (state == CAP && src == SRC_HOST) ? nib : host_rd_q;
`else
  logic unused_host;
  assign unused_host = host_req ^ (|host_rd_q);
  assign host_go = 1'b0;
  assign host_ack = 1'b0;
  assign host_rdata = 4'd0;
`endif
  assign idle = state == IDLE;
  assign host_force = host_go && host_wait >= HMW;
  assign grant_rf = idle && rf_pend;
  assign grant_host = idle && !rf_pend && host_go && (host_force || !cpu_req);
  assign grant_cpu = idle && !rf_pend && cpu_req && !host_force;
  assign nib = addr_q[0] ? arr_rdata[3:0] : arr_rdata[7:4];
  assign merged = addr_q[0] ? {arr_rdata[7:4], wdata_q} : {wdata_q, arr_rdata[3:0]};
  assign busy = !idle;
  assign arr_rd = state == RD;
  assign arr_wr = state == WB;
  assign arr_row = busy ? addr_q[3:1] : 3'd0;
  assign arr_wdata = arr_wr ? buf_q : 8'd0;
  assign cpu_ack = (src == SRC_CPU) && (state == CAP || state == WB);
  assign cpu_rdata = (state == CAP && src == SRC_CPU) ? nib : cpu_rd_q;
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state <= IDLE;
      src <= SRC_CPU;
      icnt <= '0;
      rf_pend <= 1'b0;
      rfsh <= '0;
      host_wait <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      buf_q <= '0;
      cpu_rd_q <= '0;
      host_rd_q <= '0;
    end else begin
      icnt <= (icnt == RI_LAST) ? 8'd0 : icnt + 8'd1;
      // a fresh interval tick wins over the clear so no refresh is lost
      rf_pend <= (icnt == RI_LAST) || (rf_pend && !grant_rf);
      if (!host_go || grant_host) host_wait <= '0;
      else if (grant_cpu && host_wait != 4'hf) host_wait <= host_wait + 4'd1;
      case (state)
        IDLE: if (grant_rf || grant_host || grant_cpu) begin
          state <= RD;
          src <= grant_rf ? SRC_RF : grant_host ? SRC_HOST : SRC_CPU;
          // refresh reuses the write path (read-merge-writeback) with its row in addr_q
          addr_q <= grant_rf ? {rfsh, 1'b0} : grant_host ? host_addr : cpu_addr;
          we_q <= grant_rf || (grant_host ? host_we : cpu_we);
          wdata_q <= grant_host ? host_wdata : cpu_wdata;
        end
        RD: state <= we_q ? MRG : CAP;
        CAP: begin
          state <= IDLE;
          if (src == SRC_HOST) host_rd_q <= nib;
          else cpu_rd_q <= nib;
        end
        MRG: begin
          state <= WB;
          buf_q <= (src == SRC_RF) ? arr_rdata : merged;
        end
        WB: begin
          state <= IDLE;
          if (src == SRC_RF) rfsh <= rfsh + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
